// File: rtl/cam_capture.sv
`timescale 1ns/1ps
// cam_capture: pairs OV7670 RGB565 bytes, converts each pixel to an 8-bit frame-buffer
// word (RGB332 / grayscale / colour bars) and drives the frame-buffer write port.
module cam_capture #(
  parameter int unsigned WIDTH     = 176,
  parameter int unsigned HEIGHT    = 144,
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned BAR_SHIFT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        CAM_DATA,
  input  logic [1:0]        MODE,
  output logic              W_EN,
  output logic [ADDR_W-1:0] W_ADDR,
  output logic [7:0]        W_DATA,
  output logic              FRAME_DONE,
  output logic [7:0]        FRAME_CNT,
  output logic [9:0]        LINE_LEN,
  output logic              OVERFLOW
);

  typedef enum logic [1:0] {
    MODE_RGB332 = 2'b00,
    MODE_GRAY   = 2'b01,
    MODE_BARS   = 2'b10
  } pix_mode_t;

  typedef enum logic {
    PH_HI,
    PH_LO
  } phase_t;

  localparam logic [9:0]        WIDTH_X  = 10'(WIDTH);
  localparam logic [8:0]        HEIGHT_Y = 9'(HEIGHT);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);

  phase_t            phase, phase_nx;
  pix_mode_t         mode, mode_nx;
  logic [7:0]        hi, hi_nx;
  logic [9:0]        x, x_nx;
  logic [8:0]        y, y_nx;
  logic [ADDR_W-1:0] row_base, row_nx;
  logic              href_d, vsync_d;
  logic              wrote, wrote_nx;
  logic              armed, armed_nx;

  logic              wen_nx;
  logic [ADDR_W-1:0] waddr_nx;
  logic [7:0]        wdata_nx;
  logic              done_nx;
  logic [7:0]        cnt_nx;
  logic [9:0]        len_nx;
  logic              ovf_nx;

  logic [15:0]       pixel;
  logic [4:0]        r5, b5;
  logic [5:0]        g6;
  logic [7:0]        rgb332, gray, bar_color, conv;
  logic [2:0]        bar_idx;
  logic [9:0]        x_inc;
  logic [8:0]        y_inc;
  logic [ADDR_W-1:0] pix_addr;
  logic              line_start, capture, in_bounds;

  assign pixel  = {hi, CAM_DATA};
  assign r5     = pixel[15:11];
  assign g6     = pixel[10:5];
  assign b5     = pixel[4:0];
  assign rgb332 = {r5[4:2], g6[5:3], b5[4:3]};
  // Every term of the 10-bit weighted sum has two zero LSBs, so sum[9:2] is this exact 8-bit sum.
  assign gray   = {2'b00, r5, 1'b0} + {1'b0, g6, 1'b0} + {2'b00, b5, 1'b0};

  assign bar_idx = x[BAR_SHIFT+2:BAR_SHIFT];

  always_comb begin
    case (bar_idx)
      3'd0:    bar_color = 8'hFF;
      3'd1:    bar_color = 8'hFC;
      3'd2:    bar_color = 8'h1F;
      3'd3:    bar_color = 8'h1C;
      3'd4:    bar_color = 8'hE3;
      3'd5:    bar_color = 8'hE0;
      3'd6:    bar_color = 8'h03;
      default: bar_color = 8'h00;
    endcase
  end

  always_comb begin
    case (mode)
      MODE_GRAY: conv = gray;
      MODE_BARS: conv = bar_color;
      default:   conv = rgb332;
    endcase
  end

  assign x_inc     = (x == 10'h3FF) ? x : x + 10'd1;
  assign y_inc     = (y == 9'h1FF) ? y : y + 9'd1;
  assign pix_addr  = row_base + ADDR_W'(x);
  assign in_bounds = (x < WIDTH_X) && (y < HEIGHT_Y);

  // Capture only starts on a seen HREF rise, so a line cut by reset is dropped.
  assign line_start = HREF && !href_d;
  assign capture    = HREF && (armed || line_start);

  always_comb begin
    phase_nx = phase;
    mode_nx  = mode;
    hi_nx    = hi;
    x_nx     = x;
    y_nx     = y;
    row_nx   = row_base;
    wrote_nx = wrote;
    armed_nx = armed || line_start;
    wen_nx   = 1'b0;
    waddr_nx = W_ADDR;
    wdata_nx = W_DATA;
    done_nx  = 1'b0;
    cnt_nx   = FRAME_CNT;
    len_nx   = LINE_LEN;
    ovf_nx   = OVERFLOW;

    if (VSYNC) begin
      phase_nx = PH_HI;
      x_nx     = '0;
      y_nx     = '0;
      row_nx   = '0;
      if (!vsync_d) begin
        mode_nx  = (MODE == 2'b11) ? MODE_RGB332 : pix_mode_t'(MODE);
        wrote_nx = 1'b0;
        if (wrote) begin
          done_nx = 1'b1;
          cnt_nx  = FRAME_CNT + 8'd1;
        end
      end
    end else if (capture) begin
      if (phase == PH_HI) begin
        hi_nx    = CAM_DATA;
        phase_nx = PH_LO;
      end else begin
        phase_nx = PH_HI;
        x_nx     = x_inc;
        if (in_bounds) begin
          wen_nx   = 1'b1;
          waddr_nx = pix_addr;
          wdata_nx = conv;
          wrote_nx = 1'b1;
        end else begin
          ovf_nx = 1'b1;
        end
      end
    end else if (!HREF) begin
      phase_nx = PH_HI;
      x_nx     = '0;
      if (href_d && (x != '0)) begin
        len_nx = x;
        y_nx   = y_inc;
        if (y != 9'h1FF) begin
          row_nx = row_base + ROW_STEP;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      phase      <= PH_HI;
      mode       <= MODE_RGB332;
      hi         <= '0;
      x          <= '0;
      y          <= '0;
      row_base   <= '0;
      href_d     <= 1'b1;
      vsync_d    <= 1'b0;
      wrote      <= 1'b0;
      armed      <= 1'b0;
      W_EN       <= 1'b0;
      W_ADDR     <= '0;
      W_DATA     <= '0;
      FRAME_DONE <= 1'b0;
      FRAME_CNT  <= '0;
      LINE_LEN   <= '0;
      OVERFLOW   <= 1'b0;
    end else begin
      phase      <= phase_nx;
      mode       <= mode_nx;
      hi         <= hi_nx;
      x          <= x_nx;
      y          <= y_nx;
      row_base   <= row_nx;
      href_d     <= HREF;
      vsync_d    <= VSYNC;
      wrote      <= wrote_nx;
      armed      <= armed_nx;
      W_EN       <= wen_nx;
      W_ADDR     <= waddr_nx;
      W_DATA     <= wdata_nx;
      FRAME_DONE <= done_nx;
      FRAME_CNT  <= cnt_nx;
      LINE_LEN   <= len_nx;
      OVERFLOW   <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
`timescale 1ns/1ps
// Bench for cam_capture: conversion vector table, directed frame sequences and random
// frames, all checked against a pixel-list model of the capture rules.
module tb_cam_capture;

  localparam int unsigned WIDTH     = 176;
  localparam int unsigned HEIGHT    = 144;
  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned BAR_SHIFT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              vsync;
  logic              href;
  logic [7:0]        cam_data;
  logic [1:0]        mode;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_data;
  logic              frame_done;
  logic [7:0]        frame_cnt;
  logic [9:0]        line_len;
  logic              overflow;

  cam_capture #(
    .WIDTH(WIDTH),
    .HEIGHT(HEIGHT),
    .ADDR_W(ADDR_W),
    .BAR_SHIFT(BAR_SHIFT)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .VSYNC(vsync),
    .HREF(href),
    .CAM_DATA(cam_data),
    .MODE(mode),
    .W_EN(w_en),
    .W_ADDR(w_addr),
    .W_DATA(w_data),
    .FRAME_DONE(frame_done),
    .FRAME_CNT(frame_cnt),
    .LINE_LEN(line_len),
    .OVERFLOW(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t got[$];
  wr_t exp_q[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned fd_seen  = 0;
  int unsigned b2b      = 0;
  logic        wen_prev = 1'b0;

  // Reference state: lines stored so far in the frame, latched mode, frame bookkeeping.
  int unsigned m_y      = 0;
  logic [1:0]  m_mode   = 2'd0;
  bit          m_wrote  = 1'b0;
  int unsigned exp_fd   = 0;
  logic [7:0]  exp_cnt  = 8'd0;
  logic        exp_ovf  = 1'b0;
  logic [9:0]  exp_len  = 10'd0;

  always @(negedge clk) begin
    if (w_en) got.push_back('{addr: w_addr, data: w_data});
    if (w_en && wen_prev) b2b++;
    wen_prev = w_en;
    if (frame_done) fd_seen++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] ref_pixel(input logic [1:0] md, input logic [7:0] hi,
                                           input logic [7:0] lo, input int unsigned x);
    int unsigned r, g, b;
    r = int'(hi) / 8;
    g = (int'(hi) % 8) * 8 + int'(lo) / 32;
    b = int'(lo) % 32;
    if (md == 2'd1) return 8'(2 * (r + g + b));
    if (md == 2'd2) begin
      case ((x >> BAR_SHIFT) % 8)
        0: return 8'hFF;
        1: return 8'hFC;
        2: return 8'h1F;
        3: return 8'h1C;
        4: return 8'hE3;
        5: return 8'hE0;
        6: return 8'h03;
        default: return 8'h00;
      endcase
    end
    return 8'((r / 4) * 32 + (g / 8) * 4 + b / 8);
  endfunction

  function automatic logic [31:0] got_word(input int unsigned i);
    if (i < got.size()) return 32'({got[i].addr, got[i].data});
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] word(input int unsigned addr, input logic [7:0] data);
    return 32'({ADDR_W'(addr), data});
  endfunction

  task automatic model_line(input logic [7:0] bytes[$]);
    int unsigned pairs;
    pairs = bytes.size() / 2;
    for (int unsigned i = 0; i < pairs; i++) begin
      if (i < WIDTH && m_y < HEIGHT) begin
        exp_q.push_back('{addr: ADDR_W'(m_y * WIDTH + i),
                          data: ref_pixel(m_mode, bytes[2*i], bytes[2*i+1], i)});
        m_wrote = 1'b1;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    if (pairs > 0) begin
      exp_len = 10'(pairs);
      m_y++;
    end
  endtask

  task automatic model_vsync_rise(input logic [1:0] md);
    if (m_wrote) begin
      exp_fd++;
      exp_cnt = exp_cnt + 8'd1;
    end
    m_wrote = 1'b0;
    m_mode  = (md == 2'd3) ? 2'd0 : md;
    m_y     = 0;
  endtask

  task automatic model_reset;
    m_y     = 0;
    m_mode  = 2'd0;
    m_wrote = 1'b0;
    exp_cnt = 8'd0;
    exp_ovf = 1'b0;
    exp_len = 10'd0;
    exp_q.delete();
  endtask

  task automatic send_line(input logic [7:0] bytes[$]);
    model_line(bytes);
    foreach (bytes[i]) begin
      href     = 1'b1;
      cam_data = bytes[i];
      tick;
    end
    href     = 1'b0;
    cam_data = 8'($urandom);
    tick;
    tick;
  endtask

  task automatic vsync_pulse(input logic [1:0] md);
    mode  = md;
    href  = 1'b0;
    vsync = 1'b1;
    model_vsync_rise(md);
    tick;
    tick;
    tick;
    vsync = 1'b0;
    tick;
    tick;
  endtask

  task automatic check_writes(input string name);
    int unsigned n;
    check({name, " count"}, 32'(got.size()), 32'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int unsigned i = 0; i < n; i++)
      check($sformatf("%s wr%0d", name, i), got_word(i),
            32'({exp_q[i].addr, exp_q[i].data}));
    got.delete();
    exp_q.delete();
  endtask

  task automatic check_status(input string name);
    check({name, " overflow"},   32'(overflow),  32'(exp_ovf));
    check({name, " line_len"},   32'(line_len),  32'(exp_len));
    check({name, " frame_cnt"},  32'(frame_cnt), 32'(exp_cnt));
    check({name, " frame_done"}, fd_seen,        exp_fd);
  endtask

  task automatic check_all_zero(input string name);
    check({name, " w_en"},       32'(w_en),       0);
    check({name, " w_addr"},     32'(w_addr),     0);
    check({name, " w_data"},     32'(w_data),     0);
    check({name, " frame_done"}, 32'(frame_done), 0);
    check({name, " frame_cnt"},  32'(frame_cnt),  0);
    check({name, " line_len"},   32'(line_len),   0);
    check({name, " overflow"},   32'(overflow),   0);
  endtask

  typedef struct {
    logic [1:0] md;
    logic [7:0] hi;
    logic [7:0] lo;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0]  q[$];
    int unsigned fd_before;

    vecs[0] = '{md: 2'd0, hi: 8'hF8, lo: 8'h00, data: 8'hE0};
    vecs[1] = '{md: 2'd0, hi: 8'h07, lo: 8'hE0, data: 8'h1C};
    vecs[2] = '{md: 2'd0, hi: 8'h00, lo: 8'h1F, data: 8'h03};
    vecs[3] = '{md: 2'd0, hi: 8'hA5, lo: 8'h5A, data: 8'hB7};
    vecs[4] = '{md: 2'd3, hi: 8'hF8, lo: 8'h00, data: 8'hE0};
    vecs[5] = '{md: 2'd1, hi: 8'hFF, lo: 8'hFF, data: 8'hFA};
    vecs[6] = '{md: 2'd1, hi: 8'h00, lo: 8'h00, data: 8'h00};
    vecs[7] = '{md: 2'd1, hi: 8'h84, lo: 8'h10, data: 8'h80};

    rst      = 1'b1;
    vsync    = 1'b0;
    href     = 1'b0;
    cam_data = 8'h00;
    mode     = 2'd0;
    tick;
    tick;
    check_all_zero("reset");
    rst = 1'b0;
    tick;

    // Conversion table: one single-pixel line per frame.
    for (int unsigned i = 0; i < 8; i++) begin
      vsync_pulse(vecs[i].md);
      q.delete();
      q.push_back(vecs[i].hi);
      q.push_back(vecs[i].lo);
      send_line(q);
      check($sformatf("vec%0d pixel", i), got_word(0), word(0, vecs[i].data));
      check($sformatf("vec%0d line_len", i), 32'(line_len), 1);
      check_writes($sformatf("vec%0d", i));
    end
    check_status("table");

    // Mode change mid-frame only takes effect at the next frame.
    vsync_pulse(2'd0);
    q = '{8'hF8, 8'h00, 8'h07, 8'hE0};
    send_line(q);
    check("rgb332 px0", got_word(0), word(0, 8'hE0));
    check("rgb332 px1", got_word(1), word(1, 8'h1C));
    check("rgb332 line_len", 32'(line_len), 2);
    mode = 2'd2;
    q = '{8'h12, 8'h34, 8'h56, 8'h78};
    send_line(q);
    check_writes("latch rgb");
    vsync_pulse(2'd2);
    q.delete();
    for (int unsigned i = 0; i < 64; i++) q.push_back(8'($urandom));
    send_line(q);
    check("bars x0", got_word(0), word(0, 8'hFF));
    check("bars x15", got_word(15), word(15, 8'hFF));
    check("bars x16", got_word(16), word(16, 8'hFC));
    check("bars x31", got_word(31), word(31, 8'hFC));
    check_writes("latch bars");

    // Odd byte count: dangling byte dropped, next line restarts on the high byte.
    vsync_pulse(2'd0);
    q = '{8'hA1, 8'hB2, 8'hC3};
    send_line(q);
    q = '{8'hF8, 8'h00};
    send_line(q);
    check("odd count", 32'(got.size()), 2);
    check("odd next line", got_word(1), word(WIDTH, 8'hE0));
    check_writes("odd");

    // VSYNC rising while HREF is high: no write from the pending byte pair.
    vsync_pulse(2'd0);
    q = '{8'h55, 8'hAA};
    send_line(q);
    href     = 1'b1;
    cam_data = 8'h11;
    tick;
    vsync    = 1'b1;
    cam_data = 8'h22;
    model_vsync_rise(mode);
    tick;
    href = 1'b0;
    tick;
    tick;
    vsync = 1'b0;
    tick;
    tick;
    check_writes("vsync href");
    check_status("vsync href");

    // Frames without any line produce no FRAME_DONE.
    fd_before = fd_seen;
    vsync_pulse(2'd1);
    vsync_pulse(2'd0);
    check("empty frame done", fd_seen - fd_before, 0);
    check_status("empty");

    // Random frames against the model.
    for (int unsigned f = 0; f < 8; f++) begin
      vsync_pulse(2'($urandom_range(0, 3)));
      for (int unsigned l = 0; l < $urandom_range(1, 6); l++) begin
        q.delete();
        for (int unsigned b = 0; b < $urandom_range(0, 41); b++) q.push_back(8'($urandom));
        mode = 2'($urandom_range(0, 3));
        send_line(q);
      end
      check_writes($sformatf("rand%0d", f));
      check_status($sformatf("rand%0d", f));
    end

    // Full frame geometry.
    vsync_pulse(2'd0);
    for (int unsigned l = 0; l < HEIGHT; l++) begin
      q.delete();
      for (int unsigned b = 0; b < 2 * WIDTH; b++) q.push_back(8'($urandom));
      send_line(q);
    end
    check("full count", 32'(got.size()), WIDTH * HEIGHT);
    check("full last addr", (got.size() > 0) ? 32'(got[got.size()-1].addr) : 32'hFFFF_FFFF,
          WIDTH * HEIGHT - 1);
    check_writes("full");
    fd_before = fd_seen;
    vsync_pulse(2'd0);
    check("full frame done", fd_seen - fd_before, 1);
    check_status("full");

    // Out-of-bounds lines and rows.
    for (int unsigned l = 0; l < 150; l++) begin
      q.delete();
      for (int unsigned b = 0; b < ((l < 3 || l == 149) ? 360 : 4); b++)
        q.push_back(8'($urandom));
      send_line(q);
      if (l == 0) begin
        check("ovf line0 flag", 32'(overflow), 1);
        check("ovf line0 len", 32'(line_len), 180);
      end
    end
    check("ovf count", 32'(got.size()), 3 * WIDTH + (HEIGHT - 3) * 2);
    check("ovf line_len", 32'(line_len), 180);
    check_writes("ovf");
    vsync_pulse(2'd0);
    check_status("ovf");

    // Reset in the middle of a line.
    vsync_pulse(2'd1);
    q = '{8'h00, 8'h00};
    send_line(q);
    check_writes("pre-reset");
    foreach (q[i]) q[i] = 8'h00;
    href = 1'b1;
    cam_data = 8'h10;
    tick;
    cam_data = 8'h20;
    tick;
    cam_data = 8'h30;
    tick;
    check("partial write", got_word(0), word(WIDTH, 8'h06));
    got.delete();
    rst = 1'b1;
    #1;
    check_all_zero("mid-line reset");
    tick;
    tick;
    rst = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      cam_data = 8'($urandom);
      tick;
    end
    href = 1'b0;
    tick;
    tick;
    check("dropped line", 32'(got.size()), 0);
    model_reset();
    q = '{8'hFF, 8'hFF};
    send_line(q);
    check("post-reset px", got_word(0), word(0, 8'hFF));
    check_writes("post-reset");
    check_status("post-reset");

    check("w_en back-to-back", b2b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
